// File: rtl/fir_stream_checker.sv
// Self-check block for FIR regression: compares the filter output stream with a reference
// stream, counts samples and errors, latches the first mismatch and reports a sticky verdict.
module fir_stream_checker #(
   parameter int OUTPUT_WIDTH = 16,
   parameter int NUM_CHANNELS = 1,
   parameter int TOLERANCE    = 0,
   parameter int RESP_TIMEOUT = 64,
   parameter int CNT_W        = 32,
   parameter int CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_done,
   input  logic                    valid_out,
   input  logic [OUTPUT_WIDTH-1:0] dout,
   input  logic [CH_W-1:0]         chan_out,
   input  logic                    ref_valid,
   input  logic [OUTPUT_WIDTH-1:0] ref_data,
   output logic                    ref_ready,
   output logic                    busy,
   output logic                    pass,
   output logic                    fail,
   output logic [CNT_W-1:0]        step_count,
   output logic [CNT_W-1:0]        err_count,
   output logic [CNT_W-1:0]        first_err_step,
   output logic [OUTPUT_WIDTH-1:0] first_err_dout,
   output logic [OUTPUT_WIDTH-1:0] first_err_ref,
   output logic [CH_W-1:0]         first_err_chan,
   output logic                    ref_underrun
);
   localparam int                  IDLE_W    = $clog2(RESP_TIMEOUT + 1);
   localparam logic [IDLE_W-1:0]   TIMEOUT_V = IDLE_W'(RESP_TIMEOUT);
   localparam logic [OUTPUT_WIDTH:0] TOL_V   = (OUTPUT_WIDTH + 1)'(TOLERANCE);
   localparam logic [CH_W-1:0]     CH_LAST   = CH_W'(NUM_CHANNELS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_PASS  = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   state_t                  state_r;
   logic [IDLE_W-1:0]       idle_cnt_r;
   logic [CH_W-1:0]         exp_chan_r;

   logic                    sample_s;
   logic [OUTPUT_WIDTH:0]   diff_s;
   logic [OUTPUT_WIDTH:0]   abs_s;
   logic                    data_err_s;
   logic                    chan_err_s;
   logic                    err_s;
   logic [CH_W-1:0]         next_chan_s;
   logic [IDLE_W-1:0]       idle_next_s;
   logic                    verdict_ok_s;

   assign ref_ready = valid_out & busy;

   // Per-sample error classification; the diff carries one extra bit so it never wraps.
   always_comb begin
      sample_s   = valid_out & busy;
      diff_s     = {dout[OUTPUT_WIDTH-1], dout} - {ref_data[OUTPUT_WIDTH-1], ref_data};
      if (diff_s[OUTPUT_WIDTH]) begin
         abs_s = -diff_s;
      end else begin
         abs_s = diff_s;
      end
      if (ref_valid) begin
         data_err_s = (abs_s > TOL_V);
      end else begin
         data_err_s = 1'b0;
      end
      chan_err_s = (chan_out != exp_chan_r);
      err_s      = sample_s & (~ref_valid | data_err_s | chan_err_s);
      if (exp_chan_r == CH_LAST) begin
         next_chan_s = '0;
      end else begin
         next_chan_s = exp_chan_r + 1'b1;
      end
      idle_next_s = idle_cnt_r + 1'b1;
      // Expected channel back at 0 means the sample count is a whole number of frames.
      verdict_ok_s = (err_count == '0) && (step_count != '0) && (exp_chan_r == '0);
   end

   // Control FSM, sample bookkeeping and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r        <= S_IDLE;
         idle_cnt_r     <= '0;
         exp_chan_r     <= '0;
         busy           <= 1'b0;
         pass           <= 1'b0;
         fail           <= 1'b0;
         step_count     <= '0;
         err_count      <= '0;
         first_err_step <= '0;
         first_err_dout <= '0;
         first_err_ref  <= '0;
         first_err_chan <= '0;
         ref_underrun   <= 1'b0;
      end else if (start) begin
         state_r        <= S_RUN;
         idle_cnt_r     <= '0;
         exp_chan_r     <= '0;
         busy           <= 1'b1;
         pass           <= 1'b0;
         fail           <= 1'b0;
         step_count     <= '0;
         err_count      <= '0;
         first_err_step <= '0;
         first_err_dout <= '0;
         first_err_ref  <= '0;
         first_err_chan <= '0;
         ref_underrun   <= 1'b0;
      end else begin
         if (sample_s) begin
            step_count <= step_count + 1'b1;
            exp_chan_r <= next_chan_s;
            idle_cnt_r <= '0;
            if (!ref_valid) begin
               ref_underrun <= 1'b1;
            end
            if (err_s) begin
               if (err_count != '1) begin
                  err_count <= err_count + 1'b1;
               end
               if (err_count == '0) begin
                  first_err_step <= step_count;
                  first_err_dout <= dout;
                  first_err_ref  <= ref_data;
                  first_err_chan <= chan_out;
               end
            end
         end
         case (state_r)
            S_RUN: begin
               if (in_done) begin
                  state_r    <= S_DRAIN;
                  idle_cnt_r <= '0;
               end
            end
            S_DRAIN: begin
               if (!sample_s) begin
                  if (idle_next_s == TIMEOUT_V) begin
                     state_r <= verdict_ok_s ? S_PASS : S_FAIL;
                     busy    <= 1'b0;
                     pass    <= verdict_ok_s;
                     fail    <= ~verdict_ok_s;
                  end else begin
                     idle_cnt_r <= idle_next_s;
                  end
               end
            end
            default: begin
               state_r <= state_r;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fir_stream_checker.sv
// Randomized and directed bench for fir_stream_checker against a sample-level reference model.
module tb_fir_stream_checker;
   localparam int NCH = 4;
   localparam int TOL = 1;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0, in_done = 1'b0, valid_out = 1'b0, ref_valid = 1'b0;
   logic [15:0] dout = 16'd0, ref_data = 16'd0;
   logic [1:0]  chan_out = 2'd0;
   logic        ref_ready, busy, pass, fail, ref_underrun;
   logic [31:0] step_count, err_count, first_err_step;
   logic [15:0] first_err_dout, first_err_ref;
   logic [1:0]  first_err_chan;

   int total = 0;
   int bad = 0;

   // reference model state: phase 0 idle, 1 run, 2 drain, 3 verdict
   int          m_phase = 0;
   bit          m_ok = 1'b0;
   longint      m_steps = 0, m_errs = 0;
   int          m_quiet = 0;
   bit          m_underrun = 1'b0;
   logic [31:0] m_fe_step = 32'd0;
   logic [15:0] m_fe_dout = 16'd0, m_fe_ref = 16'd0;
   logic [1:0]  m_fe_chan = 2'd0;

   fir_stream_checker #(
      .OUTPUT_WIDTH(16), .NUM_CHANNELS(NCH), .TOLERANCE(TOL), .RESP_TIMEOUT(TMO), .CNT_W(32)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_done(in_done), .valid_out(valid_out),
      .dout(dout), .chan_out(chan_out), .ref_valid(ref_valid), .ref_data(ref_data),
      .ref_ready(ref_ready), .busy(busy), .pass(pass), .fail(fail),
      .step_count(step_count), .err_count(err_count), .first_err_step(first_err_step),
      .first_err_dout(first_err_dout), .first_err_ref(first_err_ref),
      .first_err_chan(first_err_chan), .ref_underrun(ref_underrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_busy();
      return (m_phase == 1) || (m_phase == 2);
   endfunction

   task automatic m_clear(input int phase);
      m_phase = phase; m_ok = 1'b0; m_steps = 0; m_errs = 0; m_quiet = 0;
      m_underrun = 1'b0; m_fe_step = 32'd0; m_fe_dout = 16'd0; m_fe_ref = 16'd0;
      m_fe_chan = 2'd0;
   endtask

   // one clock edge of the behavioural model, using the inputs currently applied
   task automatic model_edge();
      bit smp;
      bit err;
      int d;
      if (!rst) begin
         m_clear(0);
      end else if (start) begin
         m_clear(1);
      end else begin
         smp = valid_out && m_busy();
         if (smp) begin
            d   = int'($signed(dout)) - int'($signed(ref_data));
            err = !ref_valid || (d > TOL) || (d < -TOL) ||
                  (int'(chan_out) != int'(m_steps % NCH));
            if (!ref_valid) m_underrun = 1'b1;
            if (err) begin
               if (m_errs == 0) begin
                  m_fe_step = 32'(m_steps); m_fe_dout = dout;
                  m_fe_ref = ref_data; m_fe_chan = chan_out;
               end
               m_errs++;
            end
            m_steps++;
         end
         if (m_phase == 1 && in_done) begin
            m_phase = 2; m_quiet = 0;
         end else if (m_phase == 2) begin
            if (smp) begin
               m_quiet = 0;
            end else begin
               m_quiet++;
               if (m_quiet == TMO) begin
                  m_phase = 3;
                  m_ok = (m_errs == 0) && (m_steps != 0) && (m_steps % NCH == 0);
               end
            end
         end
      end
   endtask

   task automatic check_all();
      check_val("busy", busy, m_busy());
      check_val("pass", pass, (m_phase == 3) && m_ok);
      check_val("fail", fail, (m_phase == 3) && !m_ok);
      check_val("step_count", step_count, 32'(m_steps));
      check_val("err_count", err_count, m_errs);
      check_val("first_err_step", first_err_step, m_fe_step);
      check_val("first_err_dout", first_err_dout, m_fe_dout);
      check_val("first_err_ref", first_err_ref, m_fe_ref);
      check_val("first_err_chan", first_err_chan, m_fe_chan);
      check_val("ref_underrun", ref_underrun, m_underrun);
   endtask

   // drive one cycle (called just after a falling edge), then check after the rising edge
   task automatic cyc(input bit s, input bit dn, input bit v, input logic [15:0] dd,
                      input logic [15:0] rr, input logic [1:0] ch, input bit rv);
      start = s; in_done = dn; valid_out = v; dout = dd; ref_data = rr;
      chan_out = ch; ref_valid = rv;
      #1;
      check_val("ref_ready", ref_ready, v && m_busy());
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_cyc();
      cyc(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));
   endtask

   task automatic begin_test();
      cyc(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
   endtask

   task automatic samp(input logic [15:0] dd, input logic [15:0] rr, input logic [1:0] ch,
                       input bit rv, input bit dn);
      cyc(1'b0, dn, 1'b1, dd, rr, ch, rv);
   endtask

   function automatic logic [1:0] tag();
      return 2'(m_steps % NCH);
   endfunction

   task automatic good_samp(input bit dn);
      logic [15:0] r;
      r = 16'($urandom);
      samp(r, r, tag(), 1'b1, dn);
   endtask

   task automatic rand_samp(input bit clean, input bit dn);
      logic [15:0] r, dd;
      logic [1:0]  ch;
      bit          rv;
      int          k;
      r  = 16'($urandom_range(0, 16'h3FFF)) - 16'h2000;
      dd = r + 16'($urandom_range(0, 2)) - 16'd1;
      ch = tag();
      rv = 1'b1;
      if (!clean) begin
         k = $urandom_range(0, 9);
         case (k)
            0: rv = 1'b0;
            1: ch = ch + 2'd1;
            2: dd = r + (($urandom_range(0, 1) == 0) ? 16'd2 : 16'hFFFE);
            3: begin r = 16'h8000; dd = 16'h7FFF; end
            default: dd = dd;
         endcase
      end
      samp(dd, r, ch, rv, dn);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (m_busy() && guard < 200) begin
         idle_cyc();
         guard++;
      end
      check_val("drain_done", busy, 1'b0);
   endtask

   initial begin
      @(negedge clk);
      repeat (3) idle_cyc();
      check_val("rst_step", step_count, 32'd0);
      rst = 1'b1;
      samp(16'd1, 16'd2, 2'd1, 1'b1, 1'b0);          // ignored in IDLE

      // exact stream of 100 samples
      begin_test();
      for (int i = 0; i < 100; i++) good_samp(1'b0);
      cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
      drain();
      check_val("exact_pass", pass, 1'b1);
      check_val("exact_steps", step_count, 32'd100);
      repeat (2) samp(16'd3, 16'd9, 2'd0, 1'b1, 1'b0); // ignored after verdict

      // single mismatch at step 37
      begin_test();
      for (int i = 0; i < 40; i++) begin
         if (i == 37) samp(16'h0005, 16'h0003, tag(), 1'b1, 1'b0);
         else good_samp(1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
      drain();
      check_val("mm_fail", fail, 1'b1);
      check_val("mm_err", err_count, 32'd1);
      check_val("mm_step", first_err_step, 32'd37);
      check_val("mm_dout", first_err_dout, 16'h0005);
      check_val("mm_ref", first_err_ref, 16'h0003);

      // tolerance boundaries
      begin_test();
      samp(16'hFFFD, 16'hFFFE, 2'd0, 1'b1, 1'b0);    // -3 vs -2: ok
      samp(16'hFFFC, 16'hFFFE, 2'd1, 1'b1, 1'b0);    // -4 vs -2: error
      samp(16'h7FFF, 16'h8000, 2'd2, 1'b1, 1'b0);    // diff 65535: error
      samp(16'h0001, 16'h0002, 2'd3, 1'b1, 1'b1);
      drain();
      check_val("tol_err", err_count, 32'd2);
      check_val("tol_step", first_err_step, 32'd1);

      // channel tags 0,1,2,3,0,2
      begin_test();
      for (int i = 0; i < 6; i++) begin
         logic [15:0] r;
         r = 16'($urandom);
         samp(r, r, (i == 5) ? 2'd2 : 2'(i % 4), 1'b1, i == 5);
      end
      drain();
      check_val("ch_err", err_count, 32'd1);
      check_val("ch_step", first_err_step, 32'd5);
      check_val("ch_chan", first_err_chan, 2'd2);

      // six correct samples: incomplete frame
      begin_test();
      for (int i = 0; i < 6; i++) good_samp(i == 5);
      drain();
      check_val("frame_fail", fail, 1'b1);
      check_val("frame_err", err_count, 32'd0);

      // underrun at step 10
      begin_test();
      for (int i = 0; i < 12; i++) begin
         if (i == 10) samp(16'd7, 16'd7, tag(), 1'b0, 1'b0);
         else good_samp(1'b0);
      end
      cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
      drain();
      check_val("ur_flag", ref_underrun, 1'b1);
      check_val("ur_err", err_count, 32'd1);
      check_val("ur_step", first_err_step, 32'd10);

      // start while in FAIL
      begin_test();
      check_val("restart_busy", busy, 1'b1);
      check_val("restart_err", err_count, 32'd0);
      check_val("restart_ur", ref_underrun, 1'b0);

      // reset mid-RUN
      for (int i = 0; i < 5; i++) samp(16'd1, 16'd9, tag(), 1'b1, 1'b0);
      rst = 1'b0;
      idle_cyc();
      rst = 1'b1;
      check_val("midrst_busy", busy, 1'b0);
      check_val("midrst_err", err_count, 32'd0);
      check_val("midrst_fe", first_err_dout, 16'd0);

      // no samples, then in_done
      begin_test();
      cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
      drain();
      check_val("empty_fail", fail, 1'b1);

      // sample in the final idle cycle restarts the count
      begin_test();
      for (int i = 0; i < 4; i++) good_samp(1'b0);
      cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
      repeat (TMO - 1) idle_cyc();
      good_samp(1'b0);
      check_val("late_busy", busy, 1'b1);
      repeat (3) good_samp(1'b0);
      drain();
      check_val("late_pass", pass, 1'b1);

      // start and in_done together: stays in RUN
      cyc(1'b1, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
      repeat (TMO + 2) idle_cyc();
      check_val("start_wins", busy, 1'b1);
      for (int i = 0; i < 4; i++) good_samp(i == 3);
      drain();
      check_val("sd_pass", pass, 1'b1);

      // randomized scenarios
      for (int sc = 0; sc < 30; sc++) begin
         bit clean, dn_last;
         int n;
         clean   = ($urandom_range(0, 2) == 0);
         n       = clean ? 4 * $urandom_range(1, 6) : $urandom_range(0, 20);
         dn_last = 1'b0;
         begin_test();
         for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) idle_cyc();
            dn_last = (i == n - 1) && ($urandom_range(0, 2) == 0);
            rand_samp(clean, dn_last);
         end
         if (!dn_last) cyc(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 2'd0, 1'b0);
         if (!clean && $urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(0, TMO - 2)) idle_cyc();
            rand_samp(1'b0, 1'b0);
         end
         if ($urandom_range(0, 5) == 0) begin
            rst = 1'b0;
            idle_cyc();
            rst = 1'b1;
         end else begin
            drain();
         end
         repeat (2) cyc(1'b0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom),
                        2'($urandom), 1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
